// File: rtl/ariane_pkg.sv
// Shared Ariane types; holds the state encoding of the store-drain controller.
package ariane_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      FLUSH,
      DONE,
      AMO_WAIT,
      AMO_ISSUE,
      AMO_RESP
   } store_drain_state_e;

endpackage

// File: rtl/config_pkg.sv
// Core configuration record shared by CVA6 blocks.
// Only the fields the load/store path needs are modelled here.
package config_pkg;

   typedef struct packed {
      logic [31:0] xlen;
      logic        rva_en;
      logic        dcache_wb;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/store_drain_ctrl.sv
// Store-drain controller: orders fences and AMOs behind the store buffer and arbitrates the D$ port.
// Optional drain-cycle performance counter enabled by defining STORE_DRAIN_PERF_EN.
module store_drain_ctrl
   import ariane_pkg::*;
#(
   parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
   parameter int unsigned           CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 fence_req_i,
   input  logic                 fence_i_i,
   output logic                 fence_ack_o,
   output logic                 commit_stall_o,
   input  logic                 store_buffer_empty_i,
   input  logic                 sb_req_i,
   output logic                 sb_gnt_o,
   input  logic                 amo_req_i,
   output logic                 amo_gnt_o,
   input  logic                 amo_rvalid_i,
   output logic                 dc_req_o,
   input  logic                 dc_gnt_i,
   output logic                 sel_o,
   output logic                 dcache_flush_o,
   input  logic                 dcache_flush_ack_i,
   output logic [CNT_WIDTH-1:0] drain_cycles_o
);

   store_drain_state_e state_q, state_d;

   // Flush only aborts states that have not yet started a D$ handshake.
   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (fence_req_i)    state_d = DRAIN;
            else if (amo_req_i) state_d = AMO_WAIT;
         end
         DRAIN: begin
            if (flush_i)                   state_d = IDLE;
            else if (store_buffer_empty_i) state_d = fence_i_i ? FLUSH : DONE;
         end
         FLUSH:     if (dcache_flush_ack_i)    state_d = DONE;
         DONE:                                 state_d = IDLE;
         AMO_WAIT: begin
            if (flush_i)                   state_d = IDLE;
            else if (store_buffer_empty_i) state_d = AMO_ISSUE;
         end
         AMO_ISSUE: if (dc_gnt_i && amo_req_i) state_d = AMO_RESP;
         AMO_RESP:  if (amo_rvalid_i)          state_d = IDLE;
         default:                              state_d = IDLE;
      endcase
   end

   always_comb begin
      dc_req_o       = sb_req_i;
      sb_gnt_o       = dc_gnt_i & sb_req_i;
      sel_o          = 1'b0;
      amo_gnt_o      = 1'b0;
      commit_stall_o = 1'b1;
      fence_ack_o    = 1'b0;
      dcache_flush_o = 1'b0;
      case (state_q)
         IDLE:  commit_stall_o = 1'b0;
         FLUSH: dcache_flush_o = 1'b1;
         DONE: begin
            commit_stall_o = 1'b0;
            fence_ack_o    = 1'b1;
         end
         AMO_ISSUE: begin
            dc_req_o  = amo_req_i;
            sb_gnt_o  = 1'b0;
            sel_o     = 1'b1;
            amo_gnt_o = dc_gnt_i;
         end
         AMO_RESP: begin
            dc_req_o = 1'b0;
            sb_gnt_o = 1'b0;
            sel_o    = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef STORE_DRAIN_PERF_EN
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == DRAIN || state_q == AMO_WAIT) && cnt_q != '1)
         cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   end

   assign drain_cycles_o = cnt_q;
`else
   assign drain_cycles_o = '0;
`endif

   // NOTE: reset is sampled on the clock edge, and all state uses non-blocking updates.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
`ifdef STORE_DRAIN_PERF_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
`ifdef STORE_DRAIN_PERF_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule
